instr_issue: RTL and testbench

//  Fetch/decode/issue stage driving the execution unit's instruction-side inputs (opcode, opAAdr, opBAder, dest_reg).

---
 rtl/issue_pkg.sv | 37 +++
 rtl/instr_issue_if.sv | 25 ++
 rtl/instr_decode.sv | 46 ++++
 rtl/instr_issue.sv | 119 +++++++++++
 tb/tb_instr_issue.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - opcode, state and field-layout definitions for the instruction issue stage
package issue_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'b0000,
        OP_ADD   = 4'b0001,
        OP_SUB   = 4'b0010,
        OP_AND   = 4'b0011,
        OP_LOAD  = 4'b0100,
        OP_STORE = 4'b0101,
        OP_JMP   = 4'b1100,
        OP_HALT  = 4'b1111
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_BUBBLE = 3'd3,
        S_ISSUE  = 3'd4,
        S_HALTED = 3'd5
    } state_e;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int DST_HI = 11;
    localparam int DST_LO = 9;
    localparam int OPA_HI = 8;
    localparam int OPA_LO = 6;
    localparam int OPB_HI = 5;
    localparam int OPB_LO = 3;
    localparam int TGT_HI = 7;
    localparam int TGT_LO = 0;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/instr_issue_if.sv
// rtl/instr_issue_if.sv - instruction memory and execution-unit bundle for instr_issue
interface instr_issue_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [3:0]         opcode;
    logic [2:0]         dest_reg;
    logic [2:0]         opAAdr;
    logic [2:0]         opBAder;
    logic               issue_valid;
    logic               stall;

    modport master (
        output imem_req, imem_addr, opcode, dest_reg, opAAdr, opBAder, issue_valid,
        input  imem_rdata, stall
    );

    modport slave (
        input  imem_req, imem_addr, opcode, dest_reg, opAAdr, opBAder, issue_valid,
        output imem_rdata, stall
    );
endinterface

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational field split and operand-usage decode of one instruction word
module instr_decode
    import issue_pkg::*;
(
    input  logic [15:0] i_instr,
    output logic [3:0]  o_opcode,
    output logic [2:0]  o_dest,
    output logic [2:0]  o_opa,
    output logic [2:0]  o_opb,
    output logic [7:0]  o_target,
    output logic        o_reads_a,
    output logic        o_reads_b,
    output logic        o_is_jmp,
    output logic        o_is_halt,
    output logic        o_is_load
);
    opcode_e w_op;

    assign w_op     = opcode_e'(i_instr[OPC_HI:OPC_LO]);
    assign o_opcode = i_instr[OPC_HI:OPC_LO];
    assign o_dest   = i_instr[DST_HI:DST_LO];
    assign o_opa    = i_instr[OPA_HI:OPA_LO];
    assign o_opb    = i_instr[OPB_HI:OPB_LO];
    assign o_target = i_instr[TGT_HI:TGT_LO];

    always_comb begin
        o_reads_a = 1'b0;
        o_reads_b = 1'b0;
        o_is_jmp  = 1'b0;
        o_is_halt = 1'b0;
        o_is_load = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_STORE: begin
                o_reads_a = 1'b1;
                o_reads_b = 1'b1;
            end
            OP_LOAD: begin
                o_reads_a = 1'b1;
                o_is_load = 1'b1;
            end
            OP_JMP:  o_is_jmp  = 1'b1;
            OP_HALT: o_is_halt = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/instr_issue.sv
// rtl/instr_issue.sv - fetch/decode/issue FSM with PC sequencing; load-use bubble under ISSUE_HAZARD_EN
module instr_issue
    import issue_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] PC_RESET = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          halted,
    instr_issue_if.master bus
);
    state_e             r_state;
    state_e             w_next;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;

    logic [15:0] w_dec_in;
    logic [3:0]  w_opcode;
    logic [2:0]  w_dest;
    logic [2:0]  w_opa;
    logic [2:0]  w_opb;
    logic [7:0]  w_target;
    logic        w_reads_a;
    logic        w_reads_b;
    logic        w_is_jmp;
    logic        w_is_halt;
    logic        w_is_load;
    logic        w_hazard;
    logic        w_issue;

    // One decoder serves both uses: in WAIT it looks at the incoming word for the
    // hazard check, everywhere else it looks at the latched instruction.
    assign w_dec_in = (r_state == S_WAIT) ? bus.imem_rdata : r_ir;

    instr_decode u_decode (
        .i_instr   (w_dec_in),
        .o_opcode  (w_opcode),
        .o_dest    (w_dest),
        .o_opa     (w_opa),
        .o_opb     (w_opb),
        .o_target  (w_target),
        .o_reads_a (w_reads_a),
        .o_reads_b (w_reads_b),
        .o_is_jmp  (w_is_jmp),
        .o_is_halt (w_is_halt),
        .o_is_load (w_is_load)
    );

`ifdef ISSUE_HAZARD_EN
    logic       r_ll_valid;
    logic [2:0] r_ll_dest;

    assign w_hazard = r_ll_valid &&
                      ((w_reads_a && (w_opa == r_ll_dest)) ||
                       (w_reads_b && (w_opb == r_ll_dest)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ll_valid <= 1'b0;
            r_ll_dest  <= '0;
        end else if (r_state == S_ISSUE) begin
            r_ll_valid <= w_is_load;
            r_ll_dest  <= w_dest;
        end else if (r_state == S_BUBBLE) begin
            r_ll_valid <= 1'b0;
            r_ll_dest  <= '0;
        end
    end
`else
    logic w_unused_hazard;
    assign w_hazard        = 1'b0;
    assign w_unused_hazard = w_reads_a ^ w_reads_b ^ w_is_load;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_FETCH;
            S_FETCH:  w_next = S_WAIT;
            S_WAIT:   w_next = w_hazard ? S_BUBBLE : S_ISSUE;
            S_BUBBLE: w_next = S_ISSUE;
            S_ISSUE:  if (!bus.stall) w_next = w_is_halt ? S_HALTED : S_FETCH;
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= PC_RESET;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_WAIT)
                r_ir <= bus.imem_rdata;
            if ((r_state == S_ISSUE) && !bus.stall) begin
                if (w_is_jmp)
                    r_pc <= PC_W'(w_target);
                else if (!w_is_halt)
                    r_pc <= r_pc + PC_W'(1);
            end
        end
    end

    // Fields are gated so IDLE, FETCH, WAIT, BUBBLE and HALTED all present zeros.
    assign w_issue         = (r_state == S_ISSUE);
    assign bus.imem_req    = (r_state == S_FETCH);
    assign bus.imem_addr   = (r_state == S_FETCH) ? r_pc : '0;
    assign bus.issue_valid = w_issue;
    assign bus.opcode      = w_issue ? w_opcode : 4'b0000;
    assign bus.dest_reg    = w_issue ? w_dest   : 3'b000;
    assign bus.opAAdr      = w_issue ? w_opa    : 3'b000;
    assign bus.opBAder     = w_issue ? w_opb    : 3'b000;
    assign halted          = (r_state == S_HALTED);
endmodule

// File: tb/tb_instr_issue.sv
// tb/tb_instr_issue.sv - directed self-checking bench for instr_issue
module tb_instr_issue;
    logic clk = 1'b0;
    logic reset;
    logic start;
    logic halted;
    logic [15:0] mem [0:255];
    int n_checks = 0;
    int n_fail   = 0;

    instr_issue_if #(.PC_W(8), .INSTR_W(16)) bus ();

    instr_issue #(.PC_W(8), .INSTR_W(16), .PC_RESET(8'h00)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .halted (halted),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data appears the cycle after the request.
    always @(posedge clk) begin
        if (bus.imem_req)
            bus.imem_rdata <= mem[bus.imem_addr];
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        bus.stall = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        do_reset();
        chk("reset_req",    {15'd0, bus.imem_req},    16'h0);
        chk("reset_addr",   {8'd0, bus.imem_addr},    16'h0);
        chk("reset_valid",  {15'd0, bus.issue_valid}, 16'h0);
        chk("reset_opcode", {12'd0, bus.opcode},      16'h0);
        chk("reset_halted", {15'd0, halted},          16'h0);
        step(2);
        chk("idle_no_req",  {15'd0, bus.imem_req},    16'h0);
    endtask

    task automatic test_add_jmp_halt();
        mem[8'h00] = 16'h1288;
        mem[8'h01] = 16'hC005;
        mem[8'h05] = 16'hF000;
        do_reset();
        pulse_start();
        chk("fetch0_req",  {15'd0, bus.imem_req}, 16'h1);
        chk("fetch0_addr", {8'd0, bus.imem_addr}, 16'h00);
        step(1);
        chk("wait_valid",  {15'd0, bus.issue_valid}, 16'h0);
        step(1);
        chk("add_valid",   {15'd0, bus.issue_valid}, 16'h1);
        chk("add_opcode",  {12'd0, bus.opcode},      16'h1);
        chk("add_dest",    {13'd0, bus.dest_reg},    16'h1);
        chk("add_opa",     {13'd0, bus.opAAdr},      16'h2);
        chk("add_opb",     {13'd0, bus.opBAder},     16'h1);
        step(1);
        chk("fetch1_addr", {8'd0, bus.imem_addr},    16'h01);
        step(2);
        chk("jmp_valid",   {15'd0, bus.issue_valid}, 16'h1);
        chk("jmp_opcode",  {12'd0, bus.opcode},      16'hC);
        step(1);
        chk("fetch5_addr", {8'd0, bus.imem_addr},    16'h05);
        step(2);
        chk("halt_valid",  {15'd0, bus.issue_valid}, 16'h1);
        chk("halt_opcode", {12'd0, bus.opcode},      16'hF);
        step(1);
        chk("halted",      {15'd0, halted},          16'h1);
        chk("halted_req",  {15'd0, bus.imem_req},    16'h0);
        chk("halted_valid",{15'd0, bus.issue_valid}, 16'h0);
        pulse_start();
        step(3);
        chk("halted_start_ignored", {15'd0, halted},       16'h1);
        chk("halted_req_after",     {15'd0, bus.imem_req}, 16'h0);
    endtask

    task automatic test_stall();
        mem[8'h00] = 16'h4400;
        mem[8'h01] = 16'h0000;
        do_reset();
        chk("post_halt_reset", {15'd0, halted}, 16'h0);
        pulse_start();
        step(2);
        chk("load_valid", {15'd0, bus.issue_valid}, 16'h1);
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("stall_valid",  {15'd0, bus.issue_valid}, 16'h1);
            chk("stall_opcode", {12'd0, bus.opcode},      16'h4);
            chk("stall_dest",   {13'd0, bus.dest_reg},    16'h2);
            chk("stall_req",    {15'd0, bus.imem_req},    16'h0);
        end
        bus.stall = 1'b0;
        step(1);
        chk("post_stall_req",  {15'd0, bus.imem_req}, 16'h1);
        chk("post_stall_addr", {8'd0, bus.imem_addr}, 16'h01);
    endtask

    task automatic test_load_use();
        int n;
        int exp_gap;
        mem[8'h00] = 16'h4400;
        mem[8'h01] = 16'h1688;
        do_reset();
        pulse_start();
        step(2);
        chk("lu_load_opcode", {12'd0, bus.opcode}, 16'h4);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            n++;
            if (bus.issue_valid) break;
        end
`ifdef ISSUE_HAZARD_EN
        exp_gap = 4;
`else
        exp_gap = 3;
`endif
        chk("lu_gap",    n[15:0],                  exp_gap[15:0]);
        chk("lu_opcode", {12'd0, bus.opcode},      16'h1);
        chk("lu_dest",   {13'd0, bus.dest_reg},    16'h3);
        chk("lu_opa",    {13'd0, bus.opAAdr},      16'h2);
        chk("lu_opb",    {13'd0, bus.opBAder},     16'h1);
    endtask

    task automatic test_pc_wrap();
        mem[8'h00] = 16'hC0FF;
        mem[8'hFF] = 16'h0000;
        do_reset();
        pulse_start();
        step(3);
        chk("wrap_fetch_ff", {8'd0, bus.imem_addr}, 16'hFF);
        step(2);
        chk("wrap_nop_valid", {15'd0, bus.issue_valid}, 16'h1);
        step(1);
        chk("wrap_fetch_00", {8'd0, bus.imem_addr}, 16'h00);
        chk("wrap_fetch_req", {15'd0, bus.imem_req}, 16'h1);
    endtask

    task automatic test_reset_in_wait();
        mem[8'h00] = 16'h0000;
        mem[8'h01] = 16'h0000;
        do_reset();
        pulse_start();
        step(3);
        chk("rw_fetch1", {8'd0, bus.imem_addr}, 16'h01);
        step(1);
        reset = 1'b1;
        step(1);
        chk("rw_req",    {15'd0, bus.imem_req},    16'h0);
        chk("rw_valid",  {15'd0, bus.issue_valid}, 16'h0);
        chk("rw_opcode", {12'd0, bus.opcode},      16'h0);
        chk("rw_halted", {15'd0, halted},          16'h0);
        reset = 1'b0;
        step(2);
        chk("rw_idle", {15'd0, bus.imem_req}, 16'h0);
        pulse_start();
        chk("rw_restart_req",  {15'd0, bus.imem_req}, 16'h1);
        chk("rw_restart_addr", {8'd0, bus.imem_addr}, 16'h00);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus.stall = 1'b0;
        test_reset();
        test_add_jmp_halt();
        test_stall();
        test_load_use();
        test_pc_wrap();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
